// File: rtl/tdc_pkg.sv
// Shared types and default sizing for the phase time-to-digital converter.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    WAIT  = 2'd2
  } tdc_state_e;

  localparam int CNT_W_DEF    = 16;
  localparam int AVG_LOG2_DEF = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous input, followed by one extra
// register so a single-cycle rising-edge strobe can be formed.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  // sr[STAGES-1] is the last synchronizer stage, sr[STAGES] the edge-detect delay
  logic [STAGES:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr <= '0;
    else      sr <= {sr[STAGES-1:0], d};
  end

  assign rise = sr[STAGES-1] & ~sr[STAGES];

endmodule

// File: rtl/phase_tdc.sv
// Measures clk cycles from each mod rising edge to the next sig_in rising edge,
// with a power-of-two block average and a timeout strobe for missing returns.
//
// state | meaning
// IDLE  | after reset, waiting for the first mod rising edge
// COUNT | interval counter running, waiting for the returned sig_in edge
// WAIT  | measurement taken, further sig_in edges ignored until next mod rise
module phase_tdc
  import tdc_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mod,
  input  logic             sig_in,
  output logic [CNT_W-1:0] meas_val,
  output logic             meas_valid,
  output logic [CNT_W-1:0] avg_val,
  output logic             avg_valid,
  output logic             timeout,
  output logic             busy
);

  localparam int                 ACC_W      = CNT_W + AVG_LOG2;
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [AVG_LOG2:0]  TALLY_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  tdc_state_e        state, state_nxt;
  logic              mod_d;
  logic              mod_rise;
  logic              sig_rise;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [AVG_LOG2:0] tally;
  logic              cnt_clr;
  logic              capture;
  logic              tmo;

  // mod is registered at its source, so a single delay flop is enough
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mod_d <= 1'b0;
    else      mod_d <= mod;
  end

  assign mod_rise = mod & ~mod_d;

  // Two sync stages plus the edge register cancel the mod_d delay plus the
  // FSM entry cycle, so cnt already equals the true interval on capture.
  sync_edge_det #(
    .STAGES (2)
  ) u_sig_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (sig_rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (mod_rise) state_nxt = COUNT;
      COUNT:   if (sig_rise && !mod_rise) state_nxt = WAIT;
      WAIT:    if (mod_rise) state_nxt = COUNT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr = 1'b0;
    capture = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE:  cnt_clr = mod_rise;
      COUNT: begin
        cnt_clr = mod_rise;
        capture = sig_rise;
        tmo     = mod_rise & ~sig_rise;
      end
      WAIT:  cnt_clr = mod_rise;
      default: begin
        cnt_clr = 1'b0;
      end
    endcase
  end

  assign busy = (state == COUNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (state == COUNT && cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign acc_sum = acc + ACC_W'(cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meas_val   <= '0;
      meas_valid <= 1'b0;
      avg_val    <= '0;
      avg_valid  <= 1'b0;
      timeout    <= 1'b0;
      acc        <= '0;
      tally      <= '0;
    end else begin
      meas_valid <= capture;
      timeout    <= tmo;
      avg_valid  <= 1'b0;
      if (capture) begin
        meas_val <= cnt;
        if (tally == TALLY_LAST) begin
          avg_val   <= CNT_W'(acc_sum >> AVG_LOG2);
          avg_valid <= 1'b1;
          acc       <= '0;
          tally     <= '0;
        end else begin
          acc   <= acc_sum;
          tally <= tally + (AVG_LOG2 + 1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_tdc.sv
// Scoreboard bench: three phase_tdc builds share one stimulus stream; the
// expected intervals and averages are queued as the stimulus is driven.
module tb_phase_tdc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mod = 1'b0;
  logic sig_in = 1'b0;

  always #10 clk = ~clk;

  logic [15:0] mv0, av0, mv2, av2;
  logic [7:0]  mv8, av8;
  logic        mvl0, avl0, to0, bz0;
  logic        mvl2, avl2, to2, bz2;
  logic        mvl8, avl8, to8, bz8;

  phase_tdc #(.CNT_W(16), .AVG_LOG2(0)) u_l0 (
    .clk(clk), .rst(rst), .mod(mod), .sig_in(sig_in),
    .meas_val(mv0), .meas_valid(mvl0), .avg_val(av0), .avg_valid(avl0),
    .timeout(to0), .busy(bz0));

  phase_tdc #(.CNT_W(16), .AVG_LOG2(2)) u_l2 (
    .clk(clk), .rst(rst), .mod(mod), .sig_in(sig_in),
    .meas_val(mv2), .meas_valid(mvl2), .avg_val(av2), .avg_valid(avl2),
    .timeout(to2), .busy(bz2));

  phase_tdc #(.CNT_W(8), .AVG_LOG2(2)) u_w8 (
    .clk(clk), .rst(rst), .mod(mod), .sig_in(sig_in),
    .meas_val(mv8), .meas_valid(mvl8), .avg_val(av8), .avg_valid(avl8),
    .timeout(to8), .busy(bz8));

  typedef struct {
    int meas;
    bit avg;
    int avg_val;
  } exp_t;

  exp_t q [3][$];
  int   lg   [3] = '{0, 2, 2};
  int   maxv [3] = '{65535, 65535, 255};
  int   acc  [3];
  int   tally[3];
  int   last_meas[3];
  int   last_avg [3];
  int   obs_to   [3];
  int   exp_to;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sig_drop = 0;
  bit   have_prev = 0;
  int   prev_int = 0;
  bit   mh1 = 0, mh2 = 0;

  int meas_o [3];
  int avg_o  [3];
  int flag_o [3];

  always_comb begin
    meas_o[0] = int'(mv0);
    meas_o[1] = int'(mv2);
    meas_o[2] = int'(mv8);
    avg_o[0]  = int'(av0);
    avg_o[1]  = int'(av2);
    avg_o[2]  = int'(av8);
    flag_o[0] = int'({mvl0, avl0, to0, bz0});
    flag_o[1] = int'({mvl2, avl2, to2, bz2});
    flag_o[2] = int'({mvl8, avl8, to8, bz8});
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push_meas(input int interval);
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e.meas    = (interval > maxv[i]) ? maxv[i] : interval;
      e.avg     = 1'b0;
      e.avg_val = 0;
      acc[i]   += e.meas;
      tally[i]++;
      last_meas[i] = e.meas;
      if (tally[i] == (1 << lg[i])) begin
        e.avg       = 1'b1;
        e.avg_val   = acc[i] >> lg[i];
        last_avg[i] = e.avg_val;
        acc[i]      = 0;
        tally[i]    = 0;
      end
      q[i].push_back(e);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      acc[i] = 0; tally[i] = 0; last_meas[i] = 0; last_avg[i] = 0; obs_to[i] = 0;
    end
    exp_to    = 0;
    have_prev = 0;
  endfunction

  task automatic mon(input int i, input bit mv, input int mval, input bit av,
                     input int aval, input bit to);
    exp_t e;
    if (to) begin
      obs_to[i]++;
      chk($sformatf("to_align%0d", i), int'({mh2, mh1, mod}), 3);
    end
    if (av && !mv) chk($sformatf("avg_orphan%0d", i), 1, 0);
    if (mv) begin
      if (q[i].size() == 0) begin
        chk($sformatf("meas_unexp%0d", i), mval, -1);
      end else begin
        e = q[i].pop_front();
        chk($sformatf("meas%0d", i), mval, e.meas);
        chk($sformatf("avg_flag%0d", i), int'(av), int'(e.avg));
        if (e.avg) chk($sformatf("avg%0d", i), aval, e.avg_val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, mvl0, int'(mv0), avl0, int'(av0), to0);
      mon(1, mvl2, int'(mv2), avl2, int'(av2), to2);
      mon(2, mvl8, int'(mv8), avl8, int'(av8), to8);
    end
    mh2 = mh1;
    mh1 = mod;
  end

  // Called just after a posedge; mod rises at once, sig_in is first sampled
  // high "interval" edges later.
  task automatic do_period(input int period, input int interval, input bit extra,
                           input int abort_at);
    if (have_prev && prev_int < 0) exp_to++;
    if (abort_at < 0 && interval > 0 && interval <= period - 1) push_meas(interval);
    have_prev = 1;
    prev_int  = interval;
    mod = 1'b1;
    for (int c = 0; c < period; c++) begin
      if (c == period / 2) mod = 1'b0;
      if (sig_in && cyc >= sig_drop) sig_in = 1'b0;
      if ((interval > 0 && c == interval - 1) || (extra && c == interval + 8)) begin
        sig_in   = 1'b1;
        sig_drop = cyc + 4;
      end
      if (c == abort_at) begin
        rst = 1'b0; mod = 1'b0; sig_in = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic end_phase(input string tag);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_pending%0d", tag, i), q[i].size(), 0);
      chk($sformatf("%s_meas%0d", tag, i), meas_o[i], last_meas[i]);
      chk($sformatf("%s_avg%0d", tag, i), avg_o[i], last_avg[i]);
      chk($sformatf("%s_timeouts%0d", tag, i), obs_to[i], exp_to);
    end
  endtask

  task automatic reset_check(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_meas%0d", tag, i), meas_o[i], 0);
      chk($sformatf("%s_avg%0d", tag, i), avg_o[i], 0);
      chk($sformatf("%s_flags%0d", tag, i), flag_o[i], 0);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_check("rst0");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_period(300, 100, 0, -1);
    do_period(300, 101, 0, -1);
    do_period(300, 102, 0, -1);
    do_period(300, 105, 0, -1);
    end_phase("avg4");
    do_period(300, 7, 0, -1);
    end_phase("avg5");

    do_period(10000, 1234, 0, -1);
    end_phase("basic");

    for (int p = 0; p < 3; p++) do_period(300, -1, 0, -1);
    end_phase("timeout");
    chk("timeout_busy0", int'(bz0), 1);
    chk("timeout_busy2", int'(bz2), 1);
    chk("timeout_busy8", int'(bz8), 1);

    do_period(10000, 9999, 0, -1);
    do_period(300, 50, 0, -1);
    end_phase("simul");

    do_period(600, 300, 1, -1);
    end_phase("sat");

    do_period(100, 20, 0, -1);
    do_period(100, 20, 0, -1);
    end_phase("pre_rst");

    do_period(2000, 1000, 0, 601);
    repeat (2) @(negedge clk);
    reset_check("rst_mid");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int p = 0; p < 4; p++) do_period(100, 40, 0, -1);
    end_phase("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_tdc.md
Name: phase_tdc

Overview:
- Downstream consumer of the phase controller's `mod` square wave.
- Measures, in clk cycles, the delay from each `mod` rising edge to the next rising edge of the returned external signal `sig_in`. This is the time-to-digital conversion of the loop phase.
- Produces a per-period raw measurement, a power-of-two block average, and timeout/status flags for display and readout logic.

Parameters:
- CNT_W, 16, width of the interval counter and of `meas_val`/`avg_val`.
- AVG_LOG2, 4, log2 of the number of valid measurements averaged per `avg_val` update (range 0..8).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, asynchronous, active-low.
- mod  in  1  modulation square wave from the phase controller; synchronous to clk, registered at source.
- sig_in  in  1  returned signal; asynchronous to clk.
- meas_val  out  CNT_W  last raw interval in clk cycles.
- meas_valid  out  1  one-cycle pulse when `meas_val` updates.
- avg_val  out  CNT_W  last block average.
- avg_valid  out  1  one-cycle pulse when `avg_val` updates.
- timeout  out  1  one-cycle pulse: a `mod` period ended with no `sig_in` edge.
- busy  out  1  high while in state COUNT.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Counter, accumulator and measurement tally are 0.
  - State is IDLE.
  - Synchronizer flops are 0.
- Reset is honoured mid-measurement: the in-flight count and the partial average are discarded, and no pulse is emitted.
- Edge detection:
  - `mod` passes through one register `mod_d`; `mod_rise` = `mod` & !`mod_d`.
  - `sig_in` passes through a 2-FF synchronizer (s1, s2) plus a third register s3; `sig_rise` = s2 & !s3.
- States:
  - IDLE: wait for `mod_rise`. Then go to COUNT and set cnt <= 0.
  - COUNT:
    - Each cycle, cnt <= cnt + 1, saturating at all-ones.
    - On `sig_rise`: `meas_val` <= cnt, `meas_valid` = 1, go to WAIT.
    - On `mod_rise` without `sig_rise`: `timeout` = 1, cnt <= 0, stay in COUNT.
    - On `mod_rise` and `sig_rise` in the same cycle: capture the measurement (`meas_valid` = 1), cnt <= 0, stay in COUNT. No timeout is raised.
  - WAIT: `sig_rise` is ignored. On `mod_rise`, go to COUNT and set cnt <= 0.
- `sig_rise` in IDLE or WAIT is ignored.
- Timing definition: `mod` goes high after clk edge m, and `sig_in` is first sampled high at edge k.
  - Then `meas_val` = k − m, written at edge k+2.
  - `meas_valid` is high for the cycle after edge k+2.
  - Synchronizer latency cancels against the mod edge-detect register; there is no offset.
- Saturated counts are reported as all-ones and count as valid measurements.
- Averaging:
  - Each captured measurement is added to acc (width CNT_W+AVG_LOG2) and increments tally.
  - When tally reaches 2^AVG_LOG2:
    - `avg_val` <= (acc + new) >> AVG_LOG2, truncating.
    - `avg_valid` is pulsed in the same cycle as that measurement's `meas_valid`.
    - acc and tally clear.
  - Timeouts do not affect acc or tally.
  - With AVG_LOG2 = 0, `avg_val` mirrors `meas_val`.
- Pulses are never stretched. At most one of each pulse type occurs per cycle.

Decomposition:
- Package `tdc_pkg` holds:
  - the state enum (IDLE, COUNT, WAIT) as a 2-bit typedef;
  - default constants CNT_W_DEF = 16 and AVG_LOG2_DEF = 4.
- Sub-module `sync_edge_det` (parameter STAGES, default 2): synchronizer chain plus one extra register, outputting `rise`.
  - Used once for `sig_in`.
  - `mod` uses a plain single-register edge detect inline, because it is already synchronous.

Test Plan:
- Basic interval: AVG_LOG2 = 0; `mod` toggles every 5000 cycles; `sig_in` first sampled high 1234 edges after the `mod` rise.
  - Required: `meas_val` = 1234; one `meas_valid` pulse; `avg_val` = 1234; no timeout.
- Timeout: `sig_in` held low for 3 `mod` periods after the first `mod` rise.
  - Required: exactly 2 `timeout` pulses, each on a `mod_rise` cycle; no `meas_valid`; `busy` stays 1.
- Averaging: AVG_LOG2 = 2; intervals 100, 101, 102, 105.
  - Required: four `meas_valid` pulses; a single `avg_valid` coincident with the fourth; `avg_val` = 102.
  - A following fifth interval 7 does not change `avg_val`.
- Simultaneous edges: `sig_rise` coincident with `mod_rise` while in COUNT (interval 9999).
  - Required: `meas_val` = 9999 pulsed; no timeout; the next interval of 50 is reported as 50.
- Ignore and saturation: a second `sig_in` edge in WAIT produces no pulse. CNT_W = 8 with an interval of 300 → `meas_val` = 255, valid.
- Reset mid-op: assert rst at interval count 600 with tally 3 (AVG_LOG2 = 2); release; run 4 intervals of 40.
  - Required: all outputs 0 during reset; first `avg_valid` after exactly 4 new measurements; `avg_val` = 40.
